pipeline_hazard_unit: RTL and testbench

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_forward_unit.sv | 35 +++
 rtl/pipeline_hazard_unit.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard unit.
//   hz_state_e       - multi-cycle FSM states (IDLE, BUSY)
//   FWD_RF/WB/MEM    - forwarding operand-select encodings
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: combinational operand-forwarding select for one
// Execute source register. The Memory stage has priority over Writeback,
// and register 0 is never forwarded.
// Ports:
//   i_rs        Execute source register
//   i_rdM/i_rdW Memory / Writeback destination registers
//   i_regwriteM/i_regwriteW  destination write enables
//   o_fwd       select: FWD_RF, FWD_WB or FWD_MEM
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rdM,
  input  logic [REG_AW-1:0] i_rdW,
  input  logic              i_regwriteM,
  input  logic              i_regwriteW,
  output logic [1:0]        o_fwd
);

  logic w_rs_nz;

  assign w_rs_nz = (i_rs != '0);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_rs_nz && i_regwriteM && (i_rs == i_rdM)) begin
      o_fwd = FWD_MEM;
    end else if (w_rs_nz && i_regwriteW && (i_rs == i_rdW)) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: hazard detection for a 5-stage pipeline.
//   - combinational forwarding for both Execute operands
//   - load-use stall (stall F/D, bubble E)
//   - branch/jump redirect (flush D/E), overriding load-use
//   - multi-cycle Execute op FSM (IDLE/BUSY) holding F/D/E for MC_LAT-1
//     cycles; flushM mirrors stallE
// Ports: clk, rst (sync, active high); rs1D/rs2D, rs1E/rs2E/rdE, rdM/rdW,
//   regwriteM/W, res_src_0E, mc_startE, pcsrcE in; stallF/D/E,
//   flushD/E/M, forwardAE/BE, mc_busy out.
// Optional: define HAZARD_PERF_CNT_EN to add saturating stall_cnt and
//   flush_cnt performance counters (and their ports).
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              res_src_0E,
  input  logic              mc_startE,
  input  logic              pcsrcE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              mc_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  if (MC_LAT < 2 || MC_LAT > 16 || PERF_W < 1) begin : g_param_chk
    $error("pipeline_hazard_unit: MC_LAT must be 2..16 and PERF_W >= 1");
  end

  // Busy cycles after the first: cnt counts down the remaining stalled ones.
  localparam logic [3:0] LP_CNT_INIT = 4'(MC_LAT - 2);

  hz_state_e  r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_mc_stall;
  logic       w_lu_raw;
  logic       w_lu;

  hazard_forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs        (rs1E),
    .i_rdM       (rdM),
    .i_rdW       (rdW),
    .i_regwriteM (regwriteM),
    .i_regwriteW (regwriteW),
    .o_fwd       (forwardAE)
  );

  hazard_forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs        (rs2E),
    .i_rdM       (rdM),
    .i_rdW       (rdW),
    .i_regwriteM (regwriteM),
    .i_regwriteW (regwriteW),
    .o_fwd       (forwardBE)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mc_stall  = 1'b0;
    case (r_state)
      IDLE: begin
        if (mc_startE && !pcsrcE) begin
          w_mc_stall  = 1'b1;
          w_state_nxt = BUSY;
          w_cnt_nxt   = LP_CNT_INIT;
        end
      end
      BUSY: begin
        // Last Execute cycle of the op is unstalled; mc_startE is ignored here.
        if (r_cnt != '0) begin
          w_mc_stall = 1'b1;
          w_cnt_nxt  = r_cnt - 4'd1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_lu_raw = res_src_0E && (rdE != '0) && ((rs1D == rdE) || (rs2D == rdE));
  // Load-use is held off while the multi-cycle op owns Execute.
  assign w_lu     = w_lu_raw && !w_mc_stall;

  assign stallF  = !pcsrcE && (w_mc_stall || w_lu);
  assign stallD  = !pcsrcE && (w_mc_stall || w_lu);
  assign stallE  = w_mc_stall;
  assign flushD  = pcsrcE;
  assign flushE  = pcsrcE || w_lu;
  assign flushM  = w_mc_stall;
  assign mc_busy = (r_state == BUSY);

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flushD && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

  localparam int REG_AW = 5;
  localparam int MC_LAT = 4;
  localparam int PERF_W = 2;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic              regwriteM, regwriteW, res_src_0E, mc_startE, pcsrcE;
  logic              stallF, stallD, stallE, flushD, flushE, flushM, mc_busy;
  logic [1:0]        forwardAE, forwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt, flush_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: number of BUSY cycles still ahead of the FSM.
  int m_busy_left = 0;
  int m_sc = 0;
  int m_fc = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .res_src_0E(res_src_0E), .mc_startE(mc_startE), .pcsrcE(pcsrcE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .mc_busy(mc_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_fwd(input int rs, input int dm, input int dw,
                                 input bit wm, input bit ww);
    if (rs == 0) return 0;
    if (wm && rs == dm) return 2;
    if (ww && rs == dw) return 1;
    return 0;
  endfunction

  // Expectations for the current cycle derived from the rules directly.
  bit e_mcs, e_lu, e_sF;

  task automatic eval_model();
    if (m_busy_left == 0) e_mcs = mc_startE && !pcsrcE;
    else                  e_mcs = (m_busy_left > 1);
    e_lu = res_src_0E && (rdE != 0) && (rs1D == rdE || rs2D == rdE) && !e_mcs;
    e_sF = !pcsrcE && (e_mcs || e_lu);
  endtask

  // Called just after a falling edge with inputs applied: compares all
  // outputs, then advances the model across the next rising edge.
  task automatic step();
    #1;
    eval_model();
    check_val("forwardAE", int'(forwardAE), ref_fwd(rs1E, rdM, rdW, regwriteM, regwriteW));
    check_val("forwardBE", int'(forwardBE), ref_fwd(rs2E, rdM, rdW, regwriteM, regwriteW));
    check_val("stallF", int'(stallF), int'(e_sF));
    check_val("stallD", int'(stallD), int'(e_sF));
    check_val("stallE", int'(stallE), int'(e_mcs));
    check_val("flushD", int'(flushD), int'(pcsrcE));
    check_val("flushE", int'(flushE), int'(pcsrcE || e_lu));
    check_val("flushM", int'(flushM), int'(e_mcs));
    check_val("mc_busy", int'(mc_busy), int'(m_busy_left > 0));
`ifdef HAZARD_PERF_CNT_EN
    check_val("stall_cnt", int'(stall_cnt), m_sc);
    check_val("flush_cnt", int'(flush_cnt), m_fc);
`endif
    @(posedge clk);
    if (rst) begin
      m_busy_left = 0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (m_busy_left > 0) m_busy_left--;
      else if (mc_startE && !pcsrcE) m_busy_left = MC_LAT - 1;
      if (e_sF && m_sc < PERF_MAX) m_sc++;
      if (pcsrcE && m_fc < PERF_MAX) m_fc++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    regwriteM = 0; regwriteW = 0; res_src_0E = 0; mc_startE = 0; pcsrcE = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    step();
    step();
    rst = 0;
    #1;
    check_val("reset_busy", int'(mc_busy), 0);
    check_val("reset_stallE", int'(stallE), 0);

    // Forwarding: Memory beats Writeback; x0 never forwards.
    rs1E = 5; rdM = 5; regwriteM = 1; rdW = 5; regwriteW = 1;
    #1 check_val("fwd_mem_prio", int'(forwardAE), 2);
    step();
    rs1E = 0;
    #1 check_val("fwd_x0", int'(forwardAE), 0);
    step();
    rs2E = 9; rdM = 9; regwriteM = 0; rdW = 9; regwriteW = 1;
    #1 check_val("fwd_wb", int'(forwardBE), 1);
    step();
    idle_inputs();

    // Load-use: one stall cycle, then the load has left Execute.
    res_src_0E = 1; rdE = 7; rs2D = 7;
    #1 check_val("lu_stallF", int'(stallF), 1);
    check_val("lu_flushE", int'(flushE), 1);
    step();
    res_src_0E = 0;
    #1 check_val("lu_done", int'(stallF), 0);
    step();
    res_src_0E = 1; rdE = 0; rs2D = 0;
    #1 check_val("lu_rd0", int'(stallF), 0);
    step();

    // Redirect overrides load-use.
    res_src_0E = 1; rdE = 3; rs1D = 3; pcsrcE = 1;
    #1 check_val("br_stallF", int'(stallF), 0);
    check_val("br_flushD", int'(flushD), 1);
    check_val("br_flushE", int'(flushE), 1);
    step();
    idle_inputs();

    // Multi-cycle op: stallE cycles 0..2, mc_busy cycles 1..3.
    mc_startE = 1;
    for (int k = 0; k < MC_LAT; k++) begin
      #1 check_val("mc_stallE", int'(stallE), (k < MC_LAT - 1) ? 1 : 0);
      check_val("mc_flushM", int'(flushM), int'(stallE));
      check_val("mc_busy_seq", int'(mc_busy), (k >= 1) ? 1 : 0);
      step();
    end
    mc_startE = 0;
    step();

    // Reset during BUSY cycle 1 aborts the op.
    mc_startE = 1;
    step();
    rst = 1;
    step();
    rst = 0; mc_startE = 0;
    #1 check_val("rst_abort_busy", int'(mc_busy), 0);
    check_val("rst_abort_stall", int'(stallF || stallD || stallE), 0);
    step();

`ifdef HAZARD_PERF_CNT_EN
    rst = 1;
    step();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      res_src_0E = 1; rdE = 4; rs1D = 4;
      step();
    end
    idle_inputs();
    #1 check_val("perf_sat", int'(stall_cnt), PERF_MAX);
    step();
`endif

    // Randomised traffic against the model; no redirect while Execute is held.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      rs1D       = REG_AW'($urandom_range(0, 3));
      rs2D       = REG_AW'($urandom_range(0, 3));
      rs1E       = REG_AW'($urandom_range(0, 3));
      rs2E       = REG_AW'($urandom_range(0, 3));
      rdE        = REG_AW'($urandom_range(0, 3));
      rdM        = REG_AW'($urandom_range(0, 3));
      rdW        = REG_AW'($urandom_range(0, 3));
      regwriteM  = 1'($urandom_range(0, 1));
      regwriteW  = 1'($urandom_range(0, 1));
      res_src_0E = 1'($urandom_range(0, 1));
      mc_startE  = ($urandom_range(0, 5) == 0) || (m_busy_left > 0);
      pcsrcE     = (m_busy_left <= 1) && ($urandom_range(0, 7) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
